// File: rtl/symbol_sync_error_counter_if.sv
// Symbol-stream and result bundle for the symbol sync / error counter.
// The master drives the symbol streams and receives lock and window results.
interface symbol_sync_error_counter_if #(
  parameter int SYM_BITS  = 2,
  parameter int NUM_RAILS = 2,
  parameter int MAX_DELAY = 15,
  parameter int CNT_W     = 24
);
  localparam int SW = NUM_RAILS * SYM_BITS;
  localparam int DW = $clog2(MAX_DELAY + 1);

  logic          sym_clk_ena;
  logic          restart;
  logic [SW-1:0] ref_sym;
  logic [SW-1:0] rx_sym;

  logic             locked;
  logic [DW-1:0]    delay_found;
  logic [CNT_W-1:0] sym_err_count;
  logic [CNT_W-1:0] bit_err_count;
  logic             result_valid;
  logic             lock_lost;

  modport master (
    output sym_clk_ena, restart, ref_sym, rx_sym,
    input  locked, delay_found, sym_err_count, bit_err_count, result_valid, lock_lost
  );

  modport slave (
    input  sym_clk_ena, restart, ref_sym, rx_sym,
    output locked, delay_found, sym_err_count, bit_err_count, result_valid, lock_lost
  );
endinterface

// File: rtl/symbol_sync_error_counter.sv
// Aligns the reference LFSR symbol stream to sliced receiver symbols by delay search,
// then reports saturating symbol/bit error counts over fixed windows once locked.
module symbol_sync_error_counter #(
  parameter int SYM_BITS     = 2,
  parameter int NUM_RAILS    = 2,
  parameter int MAX_DELAY    = 15,
  parameter int LOCK_LEN     = 64,
  parameter int LOCK_ERR_MAX = 4,
  parameter int WINDOW_LOG2  = 16,
  parameter int CNT_W        = 24
) (
  input logic                       sys_clk,
  input logic                       reset,
  symbol_sync_error_counter_if.slave bus
);
  localparam int SW         = NUM_RAILS * SYM_BITS;
  localparam int DW         = $clog2(MAX_DELAY + 1);
  localparam int BW         = $clog2(SW + 1);
  localparam int TW         = $clog2(LOCK_LEN);
  localparam int EW         = $clog2(LOCK_LEN + 1);
  localparam int CW1        = CNT_W + 1;
  localparam int LOSS_LIMIT = 1 << (WINDOW_LOG2 - 2);

  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;
  state_t state, state_next;

  logic [SW-1:0]          line [1:MAX_DELAY];
  logic [SW-1:0]          tap, diff;
  logic [DW-1:0]          fill_cnt, delay_q, delay_inc;
  logic [TW-1:0]          trial_cnt;
  logic [EW-1:0]          trial_err, trial_total;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [CNT_W-1:0]       sym_run, bit_run, sym_total, bit_total, sym_latch, bit_latch;
  logic [CW1-1:0]         sym_sum, bit_sum;
  logic [BW-1:0]          bit_err;
  logic                   sym_err, strobe, fill_done, trial_end, trial_pass, win_end, win_fail;
  logic                   result_valid_q, lock_lost_q;

  assign strobe = bus.sym_clk_ena && !bus.restart;

  // Tap 0 is the live input; tap d comes from the delay line.
  always_comb begin
    tap = bus.ref_sym;
    for (int k = 1; k <= MAX_DELAY; k++)
      if (delay_q == DW'(k)) tap = line[k];
  end

  assign diff    = tap ^ bus.rx_sym;
  assign sym_err = |diff;

  always_comb begin
    bit_err = '0;
    for (int i = 0; i < SW; i++) bit_err = bit_err + BW'(diff[i]);
  end

  assign fill_done   = strobe && (state == FILL) && (fill_cnt == DW'(MAX_DELAY));
  assign trial_end   = strobe && (state == SEARCH) && (trial_cnt == TW'(LOCK_LEN - 1));
  assign trial_total = trial_err + EW'(sym_err);
  assign trial_pass  = 32'(trial_total) <= 32'(LOCK_ERR_MAX);
  assign win_end     = strobe && (state == LOCKED) && (&win_cnt);
  assign sym_sum     = CW1'(sym_run) + CW1'(sym_err);
  assign bit_sum     = CW1'(bit_run) + CW1'(bit_err);
  assign sym_total   = sym_sum[CNT_W] ? '1 : sym_sum[CNT_W-1:0];
  assign bit_total   = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
  assign win_fail    = 32'(sym_total) > 32'(LOSS_LIMIT);
  assign delay_inc   = (delay_q == DW'(MAX_DELAY)) ? '0 : delay_q + DW'(1);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.restart) begin
      state_next = FILL;
    end else begin
      case (state)
        FILL:    if (fill_done) state_next = SEARCH;
        SEARCH:  if (trial_end && trial_pass) state_next = LOCKED;
        LOCKED:  if (win_end && win_fail) state_next = SEARCH;
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= MAX_DELAY; k++) line[k] <= '0;
    end else if (strobe) begin
      line[1] <= bus.ref_sym;
      for (int k = 2; k <= MAX_DELAY; k++) line[k] <= line[k-1];
    end
  end

  // Restart clears the same state as reset except the delay line, which FILL reloads.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      fill_cnt       <= '0;
      delay_q        <= '0;
      trial_cnt      <= '0;
      trial_err      <= '0;
      win_cnt        <= '0;
      sym_run        <= '0;
      bit_run        <= '0;
      sym_latch      <= '0;
      bit_latch      <= '0;
      result_valid_q <= 1'b0;
      lock_lost_q    <= 1'b0;
    end else if (bus.restart) begin
      fill_cnt       <= '0;
      delay_q        <= '0;
      trial_cnt      <= '0;
      trial_err      <= '0;
      win_cnt        <= '0;
      sym_run        <= '0;
      bit_run        <= '0;
      sym_latch      <= '0;
      bit_latch      <= '0;
      result_valid_q <= 1'b0;
      lock_lost_q    <= 1'b0;
    end else begin
      result_valid_q <= win_end;
      if (strobe && state == FILL) begin
        fill_cnt <= fill_done ? '0 : fill_cnt + DW'(1);
        if (fill_done) begin
          delay_q   <= '0;
          trial_cnt <= '0;
          trial_err <= '0;
        end
      end
      if (strobe && state == SEARCH) begin
        if (trial_end) begin
          trial_cnt <= '0;
          trial_err <= '0;
          if (trial_pass) begin
            win_cnt <= '0;
            sym_run <= '0;
            bit_run <= '0;
          end else begin
            delay_q <= delay_inc;
          end
        end else begin
          trial_cnt <= trial_cnt + TW'(1);
          trial_err <= trial_total;
        end
      end
      if (strobe && state == LOCKED) begin
        win_cnt <= win_cnt + WINDOW_LOG2'(1);
        if (win_end) begin
          sym_run   <= '0;
          bit_run   <= '0;
          sym_latch <= sym_total;
          bit_latch <= bit_total;
          if (win_fail) begin
            lock_lost_q <= 1'b1;
            delay_q     <= delay_inc;
          end
        end else begin
          sym_run <= sym_total;
          bit_run <= bit_total;
        end
      end
    end
  end

  assign bus.locked        = (state == LOCKED);
  assign bus.delay_found   = delay_q;
  assign bus.sym_err_count = sym_latch;
  assign bus.bit_err_count = bit_latch;
  assign bus.result_valid  = result_valid_q;
  assign bus.lock_lost     = lock_lost_q;
endmodule

// File: tb/tb_symbol_sync_error_counter.sv
// Bench for symbol_sync_error_counter: delay search, window error counts,
// lock loss/relock, restart priority, async reset and counter saturation.
module tb_symbol_sync_error_counter;
  logic sys_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  symbol_sync_error_counter_if #(.SYM_BITS(2), .NUM_RAILS(2), .MAX_DELAY(15), .CNT_W(24)) bus ();
  symbol_sync_error_counter_if #(.SYM_BITS(2), .NUM_RAILS(2), .MAX_DELAY(3), .CNT_W(4)) bus2 ();

  symbol_sync_error_counter #(
    .SYM_BITS(2), .NUM_RAILS(2), .MAX_DELAY(15), .LOCK_LEN(64),
    .LOCK_ERR_MAX(4), .WINDOW_LOG2(8), .CNT_W(24)
  ) dut (.sys_clk(sys_clk), .reset(reset), .bus(bus));

  symbol_sync_error_counter #(
    .SYM_BITS(2), .NUM_RAILS(2), .MAX_DELAY(3), .LOCK_LEN(8),
    .LOCK_ERR_MAX(8), .WINDOW_LOG2(6), .CNT_W(4)
  ) dut2 (.sys_clk(sys_clk), .reset(reset), .bus(bus2));

  typedef struct { int sym; int bits; } result_t;
  typedef struct { int n_single; int n_triple; int exp_sym; int exp_bit; } window_vec_t;

  result_t     sb_q [$];
  window_vec_t vecs [6];
  int          checks = 0;
  int          failures = 0;
  logic [3:0]  hist [0:31];
  int          model_delay;
  int          acc_sym;
  int          acc_bit;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Every clock goes through here so any result_valid pulse is matched against the scoreboard.
  task automatic tick();
    result_t e;
    @(posedge sys_clk);
    #1;
    if (bus.result_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected result_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("window sym_err_count", int'(bus.sym_err_count), e.sym);
        checkOutput("window bit_err_count", int'(bus.bit_err_count), e.bits);
      end
    end
  endtask

  // chan < 0 gives uncorrelated rx; otherwise rx is ref delayed by chan symbols, XOR flip.
  task automatic applyStimulus(input int chan, input logic [3:0] flip, input logic do_restart,
                               input logic push_model);
    logic [3:0] r, x, m;
    result_t    e;
    r = 4'($urandom_range(0, 15));
    if (chan < 0)       x = 4'($urandom_range(0, 15));
    else if (chan == 0) x = r;
    else                x = hist[chan-1];
    x = x ^ flip;
    if (model_delay == 0) m = r;
    else                  m = hist[model_delay-1];
    acc_sym += (m != x) ? 1 : 0;
    acc_bit += $countones(m ^ x);
    if (push_model) begin
      e.sym  = acc_sym;
      e.bits = acc_bit;
      sb_q.push_back(e);
      acc_sym = 0;
      acc_bit = 0;
    end
    for (int k = 31; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = r;
    bus.ref_sym     = r;
    bus.rx_sym      = x;
    bus.sym_clk_ena = 1'b1;
    bus.restart     = do_restart;
    tick();
    bus.sym_clk_ena = 1'b0;
    bus.restart     = 1'b0;
  endtask

  task automatic waitLock(input int chan, input int budget, output int n);
    n = -1;
    for (int s = 1; s <= budget; s++) begin
      applyStimulus(chan, 4'h0, 1'b0, 1'b0);
      if (bus.locked) begin
        n = s;
        break;
      end
    end
  endtask

  task automatic checkAllClear(input string tag);
    checkOutput({tag, " locked"}, int'(bus.locked), 0);
    checkOutput({tag, " delay_found"}, int'(bus.delay_found), 0);
    checkOutput({tag, " sym_err_count"}, int'(bus.sym_err_count), 0);
    checkOutput({tag, " bit_err_count"}, int'(bus.bit_err_count), 0);
    checkOutput({tag, " result_valid"}, int'(bus.result_valid), 0);
    checkOutput({tag, " lock_lost"}, int'(bus.lock_lost), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    result_t    exp_r;
    logic [3:0] flip;
    logic [3:0] r2;
    int         n;

    bus.sym_clk_ena  = 1'b0;
    bus.restart      = 1'b0;
    bus.ref_sym      = '0;
    bus.rx_sym       = '0;
    bus2.sym_clk_ena = 1'b0;
    bus2.restart     = 1'b0;
    bus2.ref_sym     = '0;
    bus2.rx_sym      = '0;
    for (int k = 0; k < 32; k++) hist[k] = 4'h0;
    model_delay = 0;
    acc_sym     = 0;
    acc_bit     = 0;

    vecs[0] = '{5, 1, 6, 8};
    vecs[1] = '{0, 0, 0, 0};
    vecs[2] = '{12, 3, 15, 21};
    vecs[3] = '{0, 10, 10, 30};
    vecs[4] = '{64, 0, 64, 64};
    vecs[5] = '{40, 24, 64, 112};

    repeat (3) @(posedge sys_clk);
    #1;
    checkAllClear("reset");
    reset = 1'b1;
    tick();

    $display("[TB] lock search with channel delay 7");
    waitLock(7, 1000, n);
    checkOutput("strobes to lock at delay 7", n, 16 + 7 * 64 + 64);
    checkOutput("delay_found after lock 7", int'(bus.delay_found), 7);

    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    checkAllClear("after restart");

    $display("[TB] relock at channel delay 3 and window table");
    waitLock(3, 600, n);
    checkOutput("strobes to lock at delay 3", n, 16 + 3 * 64 + 64);
    checkOutput("delay_found after lock 3", int'(bus.delay_found), 3);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 256; i++) begin
        if (i < vecs[v].n_single)                         flip = 4'(1 << (i % 4));
        else if (i < vecs[v].n_single + vecs[v].n_triple) flip = 4'b0111;
        else                                              flip = 4'h0;
        if (i == 255) begin
          exp_r.sym  = vecs[v].exp_sym;
          exp_r.bits = vecs[v].exp_bit;
          sb_q.push_back(exp_r);
        end
        applyStimulus(3, flip, 1'b0, 1'b0);
      end
      checkOutput($sformatf("window %0d locked", v), int'(bus.locked), 1);
      checkOutput($sformatf("window %0d lock_lost", v), int'(bus.lock_lost), 0);
    end

    $display("[TB] channel delay moves from 3 to 5");
    model_delay = 3;
    acc_sym     = 0;
    acc_bit     = 0;
    for (int i = 0; i < 256; i++) applyStimulus(5, 4'h0, 1'b0, (i == 255));
    checkOutput("loss locked", int'(bus.locked), 0);
    checkOutput("loss lock_lost", int'(bus.lock_lost), 1);
    checkOutput("loss delay_found", int'(bus.delay_found), 4);
    waitLock(5, 300, n);
    checkOutput("strobes to relock at 5", n, 128);
    checkOutput("relock delay_found", int'(bus.delay_found), 5);
    checkOutput("relock lock_lost sticky", int'(bus.lock_lost), 1);

    $display("[TB] restart on a window's final strobe");
    for (int i = 0; i < 255; i++) applyStimulus(5, 4'h0, 1'b0, 1'b0);
    applyStimulus(5, 4'h0, 1'b1, 1'b0);
    checkAllClear("restart at window end");
    tick();
    checkOutput("no late result_valid", int'(bus.result_valid), 0);
    waitLock(5, 600, n);
    checkOutput("strobes to lock after restart", n, 16 + 5 * 64 + 64);

    $display("[TB] asynchronous reset mid-window");
    repeat (100) applyStimulus(5, 4'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset locked", int'(bus.locked), 0);
    checkOutput("async reset delay_found", int'(bus.delay_found), 0);
    checkOutput("async reset lock_lost", int'(bus.lock_lost), 0);
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] uncorrelated rx: search cycles all delays");
    for (int s = 1; s <= 16 + 64 * 17; s++) begin
      applyStimulus(-1, 4'h0, 1'b0, 1'b0);
      if (s >= 16 && ((s - 16) % 64) == 0) begin
        checkOutput($sformatf("random delay_found @%0d", s), int'(bus.delay_found), ((s - 16) / 64) % 16);
        checkOutput($sformatf("random locked @%0d", s), int'(bus.locked), 0);
      end
    end

    $display("[TB] saturation with 4-bit counters");
    for (int s = 1; s <= 12 + 64; s++) begin
      r2 = 4'($urandom_range(0, 15));
      bus2.ref_sym     = r2;
      bus2.rx_sym      = ~r2;
      bus2.sym_clk_ena = 1'b1;
      tick();
      bus2.sym_clk_ena = 1'b0;
      if (s == 11) checkOutput("sat locked before trial end", int'(bus2.locked), 0);
      if (s == 12) checkOutput("sat forced lock", int'(bus2.locked), 1);
      if (s == 76) begin
        checkOutput("sat result_valid", int'(bus2.result_valid), 1);
        checkOutput("sat sym_err_count", int'(bus2.sym_err_count), 15);
        checkOutput("sat bit_err_count", int'(bus2.bit_err_count), 15);
      end
    end

    checkOutput("pending scoreboard entries", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
